pipeline_hazard_ctrl: RTL and testbench

// - Central hazard and sequencing controller for the 5-stage MIPS pipeline.
// - Drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM stage registers.
// - Handles three cases: load-use stalls, taken-branch flushes, and multi-cycle EX ops (MULT/DIV) that hold the EX stage.
// - Sits beside the decoder; sees ID source regs and EX/MEM destination info.

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of decoder-side hazard inputs and stage-register controls for pipeline_hazard_ctrl.
// Dbg_State mirrors the controller FSM (0 = RUN, 1 = MCOP) for observation only.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic [REG_W-1:0] EX_Rd;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [REG_W-1:0] MEM_Rd;
  logic             MEM_RegWrite;
  logic             EX_BranchTaken;
  logic             EX_MultiStart;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EX_Hold;
  logic             EXMEM_Bubble;
  logic             MC_Done;
  logic [15:0]      Stall_Count;
  logic             Dbg_State;

  // master: the pipeline datapath side; slave: the hazard controller.
  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_Rd, EX_RegWrite, EX_MemRead,
           MEM_Rd, MEM_RegWrite, EX_BranchTaken, EX_MultiStart,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EX_Hold,
           EXMEM_Bubble, MC_Done, Stall_Count, Dbg_State
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rd, EX_RegWrite, EX_MemRead,
           MEM_Rd, MEM_RegWrite, EX_BranchTaken, EX_MultiStart,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EX_Hold,
           EXMEM_Bubble, MC_Done, Stall_Count, Dbg_State
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch flushes, MULT/DIV hold.
// Optional macro FORWARDING_EN: when defined, only load-use hazards stall (forwarding covers the rest).
module pipeline_hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int REG_W      = 5
) (
  input  logic                    Clk,
  input  logic                    Rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic {
    RUN  = 1'b0,
    MCOP = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       ex_match;
  logic       mem_match;
  logic       data_stall;

  // Register $0 is hardwired to zero, so it never creates a dependence.
  function automatic logic reg_match(input logic [REG_W-1:0] x,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (x != '0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  assign ex_match  = reg_match(hz.EX_Rd,  hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt);
  assign mem_match = reg_match(hz.MEM_Rd, hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt);

`ifdef FORWARDING_EN
  assign data_stall = hz.EX_MemRead && ex_match;
`else
  assign data_stall = (hz.EX_RegWrite && ex_match) || (hz.MEM_RegWrite && mem_match);
`endif

  assign hz.Dbg_State = state;

  always_comb begin
    hz.PC_Write     = 1'b1;
    hz.IFID_Write   = 1'b1;
    hz.IFID_Flush   = 1'b0;
    hz.IDEX_Flush   = 1'b0;
    hz.EX_Hold      = 1'b0;
    hz.EXMEM_Bubble = 1'b0;
    if (Rst) begin
      hz.PC_Write     = 1'b0;
      hz.IFID_Write   = 1'b0;
      hz.IFID_Flush   = 1'b1;
      hz.IDEX_Flush   = 1'b1;
      hz.EXMEM_Bubble = 1'b1;
    end else if (state == MCOP) begin
      hz.PC_Write     = 1'b0;
      hz.IFID_Write   = 1'b0;
      hz.EX_Hold      = 1'b1;
      hz.EXMEM_Bubble = 1'b1;
    end else if (hz.EX_BranchTaken) begin
      // The ID instruction is squashed, so any data stall on it is moot.
      hz.IFID_Flush   = 1'b1;
      hz.IDEX_Flush   = 1'b1;
    end else if (data_stall) begin
      hz.PC_Write     = 1'b0;
      hz.IFID_Write   = 1'b0;
      hz.IDEX_Flush   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= RUN;
      cnt            <= 4'd0;
      hz.MC_Done     <= 1'b0;
      hz.Stall_Count <= 16'd0;
    end else begin
      hz.MC_Done <= 1'b0;
      case (state)
        RUN: begin
          if (hz.EX_MultiStart && !hz.EX_BranchTaken) begin
            state <= MCOP;
            cnt   <= CNT_INIT;
          end
        end
        MCOP: begin
          if (cnt == 4'd0) begin
            state      <= RUN;
            hz.MC_Done <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
      if (!hz.PC_Write && (hz.Stall_Count != 16'hFFFF))
        hz.Stall_Count <= hz.Stall_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl (default build, FORWARDING_EN undefined).
// Expected output words go through a scoreboard queue and are compared mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic Clk;
  logic Rst;

  pipeline_hazard_ctrl_if #(.REG_W(5)) u_if  ();
  pipeline_hazard_ctrl_if #(.REG_W(5)) u_if1 ();

  pipeline_hazard_ctrl #(.MC_LATENCY(4), .REG_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (u_if.slave)
  );

  pipeline_hazard_ctrl #(.MC_LATENCY(1), .REG_W(5)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (u_if1.slave)
  );

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Packed word: {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EX_Hold, EXMEM_Bubble, MC_Done, Stall_Count, state}
  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic       br;
    logic       ms;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urt, input logic [4:0] ex_rd, input logic ex_rw,
                              input logic ex_mr, input logic [4:0] mem_rd, input logic mem_rw,
                              input logic br, input logic ms, input logic [6:0] o,
                              input logic [15:0] sc, input logic st);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt;
    v.ex_rd = ex_rd; v.ex_rw = ex_rw; v.ex_mr = ex_mr;
    v.mem_rd = mem_rd; v.mem_rw = mem_rw; v.br = br; v.ms = ms;
    v.exp = {o, sc, st};
    return v;
  endfunction

  function automatic logic [23:0] obs0();
    return {u_if.PC_Write, u_if.IFID_Write, u_if.IFID_Flush, u_if.IDEX_Flush,
            u_if.EX_Hold, u_if.EXMEM_Bubble, u_if.MC_Done, u_if.Stall_Count, u_if.Dbg_State};
  endfunction

  function automatic logic [23:0] obs1();
    return {u_if1.PC_Write, u_if1.IFID_Write, u_if1.IFID_Flush, u_if1.IDEX_Flush,
            u_if1.EX_Hold, u_if1.EXMEM_Bubble, u_if1.MC_Done, u_if1.Stall_Count, u_if1.Dbg_State};
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    Rst                 = v.rst;
    u_if.ID_Rs          = v.rs;
    u_if.ID_Rt          = v.rt;
    u_if.ID_UsesRt      = v.urt;
    u_if.EX_Rd          = v.ex_rd;
    u_if.EX_RegWrite    = v.ex_rw;
    u_if.EX_MemRead     = v.ex_mr;
    u_if.MEM_Rd         = v.mem_rd;
    u_if.MEM_RegWrite   = v.mem_rw;
    u_if.EX_BranchTaken = v.br;
    u_if.EX_MultiStart  = v.ms;
    exp_q.push_back(v.exp);
  endtask

  task automatic idle1(input logic ms);
    u_if1.ID_Rs = '0; u_if1.ID_Rt = '0; u_if1.ID_UsesRt = 1'b0;
    u_if1.EX_Rd = '0; u_if1.EX_RegWrite = 1'b0; u_if1.EX_MemRead = 1'b0;
    u_if1.MEM_Rd = '0; u_if1.MEM_RegWrite = 1'b0; u_if1.EX_BranchTaken = 1'b0;
    u_if1.EX_MultiStart = ms;
  endtask

  // Scoreboard
  task automatic check_pop(input string name, input logic [23:0] act);
    logic [23:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %b but scoreboard queue is empty", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b want %b", name, act, e);
    end
  endtask

  initial begin
    //            rst rs rt urt exrd rw mr memrd mrw br ms  outputs    sc  st
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 16'd0, 0)); // reset outputs
    tbl.push_back(mk(0, 1, 2, 1, 3, 1, 0, 4, 1, 0, 0, 7'b1100000, 16'd0, 0)); // no hazard
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 7'b1100000, 16'd0, 0)); // $0 never matches
    tbl.push_back(mk(0, 8, 0, 0, 8, 1, 1, 0, 0, 0, 0, 7'b0001000, 16'd0, 0)); // load-use
    tbl.push_back(mk(0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 7'b0001000, 16'd1, 0)); // EX RAW on rt
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 5, 1, 0, 0, 7'b0001000, 16'd2, 0)); // MEM RAW on rt
    tbl.push_back(mk(0, 6, 5, 0, 5, 1, 0, 0, 0, 0, 0, 7'b1100000, 16'd3, 0)); // rt unused
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0, 7'b0001000, 16'd3, 0)); // MEM RAW on rs
    tbl.push_back(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 7'b1100000, 16'd4, 0)); // no RegWrite
    tbl.push_back(mk(0, 8, 0, 0, 8, 1, 1, 0, 0, 1, 0, 7'b1111000, 16'd4, 0)); // branch beats stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111000, 16'd4, 0)); // branch beats multi
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 16'd4, 0)); // still RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1100000, 16'd4, 0)); // multi start
    tbl.push_back(mk(0, 8, 0, 0, 8, 1, 1, 0, 0, 1, 1, 7'b0000110, 16'd4, 1)); // MCOP 1, inputs ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 16'd5, 1)); // MCOP 2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 16'd6, 1)); // MCOP 3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 16'd7, 1)); // MCOP 4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100001, 16'd8, 0)); // MC_Done pulse
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 16'd8, 0)); // pulse over
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1100000, 16'd8, 0)); // multi start
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 16'd8, 1)); // MCOP 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 16'd9, 1)); // reset in MCOP 2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 16'd0, 0)); // op abandoned
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 16'd0, 0)); // no late MC_Done

    Rst = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 16'd0, 0));
    void'(exp_q.pop_front());
    idle1(1'b0);
    repeat (2) @(posedge Clk);

    foreach (tbl[i]) begin
      @(negedge Clk);
      drive(tbl[i]);
      #2;
      check_pop($sformatf("row%0d", i), obs0());
    end

    // MC_LATENCY=1: MCOP lasts one cycle, MC_Done on the following one.
    @(negedge Clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 16'd0, 0));
    void'(exp_q.pop_front());
    idle1(1'b1);
    exp_q.push_back({7'b1100000, 16'd0, 1'b0});
    #2 check_pop("lat1_start", obs1());
    @(negedge Clk);
    idle1(1'b0);
    exp_q.push_back({7'b0000110, 16'd0, 1'b1});
    #2 check_pop("lat1_mcop", obs1());
    @(negedge Clk);
    exp_q.push_back({7'b1100001, 16'd1, 1'b0});
    #2 check_pop("lat1_done", obs1());
    @(negedge Clk);
    exp_q.push_back({7'b1100000, 16'd1, 1'b0});
    #2 check_pop("lat1_after", obs1());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
